// File: rtl/clk_div_sched.sv
// Two-requester burst scheduler driving a divide-by-N counter; `CLK_DIV_SCHED_RR_EN selects round-robin over fixed priority.
// Grant is combinational in IDLE; a burst lasts L*N cycles (plus held cycles) and readies stay low until it ends.
module clk_div_sched #(
    parameter int CNT_W = 3,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_req0_valid,
    input  logic [CNT_W-1:0] i_req0_div,
    input  logic [LEN_W-1:0] i_req0_len,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [CNT_W-1:0] i_req1_div,
    input  logic [LEN_W-1:0] i_req1_len,
    output logic             o_req1_ready,
    input  logic             i_hold,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_owner,
    output logic [CNT_W-1:0] o_count,
    output logic             o_count_end,
    output logic             o_div_clk,
    output logic             o_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] n_r, cnt, cnt_nxt, sel_div, req_n;
    logic [LEN_W-1:0] rem, sel_len, req_l;
    logic [CNT_W:0]   half;
    logic             owner, div_clk, done, abort_flag;
    logic             grant0, grant1, hs, count_end, burst_end, idle;

    assign idle = (state == IDLE);

`ifdef CLK_DIV_SCHED_RR_EN
    logic rr;

    // rr names the requester that wins the next tie.
    assign grant0 = idle & i_req0_valid & (~i_req1_valid | ~rr);
    assign grant1 = idle & i_req1_valid & (~i_req0_valid | rr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rr <= 1'b0;
        else if (hs)
            rr <= grant0;
    end
`else
    assign grant0 = idle & i_req0_valid;
    assign grant1 = idle & i_req1_valid & ~i_req0_valid;
`endif

    assign hs      = grant0 | grant1;
    assign sel_div = grant1 ? i_req1_div : i_req0_div;
    assign sel_len = grant1 ? i_req1_len : i_req0_len;
    assign req_n   = (sel_div < CNT_W'(2)) ? CNT_W'(2) : sel_div;
    assign req_l   = (sel_len == '0) ? LEN_W'(1) : sel_len;

    assign count_end = (state == RUN) & (cnt == n_r - CNT_W'(1)) & ~i_hold;
    assign burst_end = count_end & ((rem == LEN_W'(1)) | abort_flag | i_abort);
    assign cnt_nxt   = count_end ? '0 : cnt + CNT_W'(1);
    // Computed one bit wider so N at full scale does not overflow.
    assign half      = ({1'b0, n_r} + 1'b1) >> 1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = RUN;
            RUN:     if (burst_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            n_r        <= '0;
            rem        <= '0;
            cnt        <= '0;
            owner      <= 1'b0;
            div_clk    <= 1'b0;
            done       <= 1'b0;
            abort_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                abort_flag <= 1'b0;
                if (hs) begin
                    owner   <= grant1;
                    n_r     <= req_n;
                    rem     <= req_l;
                    cnt     <= '0;
                    div_clk <= 1'b1;
                end
            end else begin
                if (i_abort)
                    abort_flag <= 1'b1;
                if (burst_end) begin
                    cnt        <= '0;
                    div_clk    <= 1'b0;
                    done       <= 1'b1;
                    abort_flag <= 1'b0;
                end else if (!i_hold) begin
                    cnt     <= cnt_nxt;
                    div_clk <= ({1'b0, cnt_nxt} < half);
                    if (count_end)
                        rem <= rem - LEN_W'(1);
                end
            end
        end
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;
    assign o_busy       = (state == RUN);
    assign o_owner      = owner;
    assign o_count      = cnt;
    assign o_count_end  = count_end;
    assign o_div_clk    = div_clk;
    assign o_done       = done;

endmodule

// File: doc/clk_div_sched.md
# clk_div_sched

Scheduler and sequencer for the programmable clock-divider datapath. Two requesters each ask for a burst of divided-clock periods at a chosen divide ratio. The block arbitrates between them and runs the internal divide-by-N counter for the granted burst. It generates `o_count`, `o_count_end` and `o_div_clk`, and it gates the counter with `i_hold` (count-valid) and `i_abort`.

## Interface
- `CNT_W`, 3: width of the divide counter and ratio fields.
- `LEN_W`, 8: width of the burst-length fields.
- `clk` in 1: single system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `i_req0_valid` in 1: requester 0 has a burst pending.
- `i_req0_div` in CNT_W: requester 0 divide ratio N.
- `i_req0_len` in LEN_W: requester 0 burst length L, in divided periods.
- `o_req0_ready` out 1: requester 0 granted; handshake completes when valid and ready are both high.
- `i_req1_valid`, `i_req1_div`, `i_req1_len`, `o_req1_ready`: same as above, for requester 1.
- `i_hold` in 1: freeze counting while in RUN (count-valid low).
- `i_abort` in 1: end the burst at the next period boundary.
- `o_busy` out 1: high in RUN.
- `o_owner` out 1: index of the requester that owns the current or last burst.
- `o_count` out CNT_W: divide counter value.
- `o_count_end` out 1: final count of the current period.
- `o_div_clk` out 1: divided clock.
- `o_done` out 1: one-cycle pulse when a burst ends.

## Operation
- States:
  - IDLE: counter at 0, `o_div_clk`=0, `o_busy`=0.
  - RUN: counter active.
- Arbitration, IDLE only:
  - `o_reqX_ready` is combinational from state, valids and the rr pointer. At most one ready is high.
  - Outside IDLE, both readies are 0.
  - Handshake captures the requester's N, L and index (`o_owner`). The state goes to RUN.
- Ratio and length sanitising:
  - N<2 is treated as N=2.
  - L=0 is treated as L=1.
- RUN counting:
  - `o_count` steps 0..N-1 and wraps to 0.
  - `o_count_end` = RUN & `o_count`==N-1 & !`i_hold` (combinational).
  - Each `o_count_end` decrements the remaining-period count.
- `o_div_clk` duty:
  - Registered, and updated on the same edge as `o_count`.
  - High while `o_count` < H, where H=(N+1)>>1; low otherwise. Example: N=7 gives 4 high, 3 low.
- `i_hold`: while high in RUN, `o_count`, `o_div_clk` and the period count all hold.
- Burst end:
  - Triggered by `o_count_end` on the last period, or on any period once the abort flag is set.
  - Go to IDLE; `o_count`←0, `o_div_clk`←0, `o_done`←1 for one cycle.
- Abort:
  - `i_abort` high in RUN sets a sticky abort flag. The current period always completes.
  - `i_abort` in IDLE is ignored. The flag clears on entry to IDLE.
- rr pointer: after each grant, it points to the other requester.

## Timing
- Reset values:
  - State IDLE, rr pointer = requester 0.
  - All outputs 0: `o_busy`, `o_owner`, `o_count`, `o_count_end`, `o_div_clk`, `o_done`, and both readies (combinational, so 0 until a valid arrives).
- Handshake at edge T:
  - From T: `o_busy`=1, `o_count`=0, `o_div_clk`=1.
  - Without hold, burst duration is exactly L·N cycles; `o_done` is high in cycle T+L·N.
- Back-to-back: a new handshake is allowed in the same cycle `o_done` is high, giving exactly 1 idle cycle between bursts.
- Simultaneous events:
  - `i_hold` and the last-period end in the same cycle: hold wins, and the burst ends at the first non-held N-1 cycle.
  - `i_abort` together with `o_count_end` in the same cycle: the burst ends at that edge.
- Reset mid-burst: immediate asynchronous return to the reset values. No `o_done` pulse.

## Configuration
- `CLK_DIV_SCHED_RR_EN`:
  - Defined: round-robin arbitration, as described above.
  - Undefined: fixed priority, requester 0 always wins ties. The rr pointer is removed.
  - Single-requester behaviour is identical in both builds.

## Test plan
- Reset, then req0 with N=7, L=2 -> `o_div_clk` pattern 1111000 twice; `o_count_end` at cycles T+6 and T+13; `o_done` at T+14; `o_owner`=0.
- Both valid in IDLE, N=3/L=1 each, RR build -> req0 granted first, req1 granted in the `o_done` cycle. Fixed-priority build with req0 held valid -> req1 never granted.
- N=4, L=3, `i_hold` high for 5 cycles mid-period -> `o_count` frozen for those 5 cycles; `o_done` at T+12+5.
- N=5, L=10, `i_abort` pulsed at `o_count`=2 of period 1 -> burst ends after period 1; `o_done` at T+10.
- N=0 and L=0 requested -> behaves as N=2, L=1: `o_div_clk` 1,0; `o_done` at T+2.
- `resetn` asserted while `o_count`=3 -> all outputs 0 immediately; no `o_done`; the next request is accepted normally after release.
